// File: rtl/mem_port_arbiter.sv
// Arbiter that shares one multi-cycle word-addressed memory between instruction
// fetch and data access, one transaction at a time, with one-cycle acks.
module mem_port_arbiter #(
  parameter int AW         = 32,
  parameter int DW         = 32,
  parameter int TIMEOUT    = 255,
  parameter int STARVE_MAX = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          if_req,
  input  logic [AW-1:0] if_addr,
  output logic          if_ack,
  output logic [DW-1:0] if_rdata,
  input  logic          dm_req,
  input  logic          dm_we,
  input  logic [AW-1:0] dm_addr,
  input  logic [DW-1:0] dm_wdata,
  output logic          dm_ack,
  output logic [DW-1:0] dm_rdata,
  output logic          stall_if,
  output logic          stall_dm,
  output logic          mem_req,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  input  logic          mem_ready,
  output logic          err_timeout
);

  localparam int WCW = $clog2(TIMEOUT + 1);
  localparam int SCW = $clog2(STARVE_MAX + 1);
  localparam logic [WCW-1:0] WAIT_LAST  = WCW'(TIMEOUT - 1);
  localparam logic [SCW-1:0] STARVE_LIM = SCW'(STARVE_MAX);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    SERVE_IF = 2'd1,
    SERVE_DM = 2'd2,
    ACK      = 2'd3
  } state_t;

  state_t         r_state;
  logic [WCW-1:0] r_wait_cnt;
  logic [SCW-1:0] r_starve_cnt;
  logic           w_fetch_wins;

  // A pending fetch only beats a pending data request once it has been starved.
  assign w_fetch_wins = if_req && (!dm_req || (r_starve_cnt == STARVE_LIM));

  assign stall_if = if_req & ~if_ack;
  assign stall_dm = dm_req & ~dm_ack;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= IDLE;
      r_wait_cnt   <= '0;
      r_starve_cnt <= '0;
      mem_req      <= 1'b0;
      mem_we       <= 1'b0;
      mem_addr     <= '0;
      mem_wdata    <= '0;
      if_ack       <= 1'b0;
      dm_ack       <= 1'b0;
      if_rdata     <= '0;
      dm_rdata     <= '0;
      err_timeout  <= 1'b0;
    end else begin
      if_ack <= 1'b0;
      dm_ack <= 1'b0;
      case (r_state)
        IDLE: begin
          r_wait_cnt <= '0;
          if (w_fetch_wins) begin
            r_state      <= SERVE_IF;
            mem_req      <= 1'b1;
            mem_we       <= 1'b0;
            mem_addr     <= if_addr;
            mem_wdata    <= '0;
            r_starve_cnt <= '0;
          end else if (dm_req) begin
            r_state   <= SERVE_DM;
            mem_req   <= 1'b1;
            mem_we    <= dm_we;
            mem_addr  <= dm_addr;
            mem_wdata <= dm_wdata;
            if (!if_req) begin
              r_starve_cnt <= '0;
            end else if (r_starve_cnt != STARVE_LIM) begin
              r_starve_cnt <= r_starve_cnt + SCW'(1);
            end else begin
              r_starve_cnt <= r_starve_cnt;
            end
          end else begin
            r_state <= IDLE;
          end
        end
        SERVE_IF, SERVE_DM: begin
          if (mem_ready || (r_wait_cnt == WAIT_LAST)) begin
            // Completion and timeout share the ack path; timeout returns zero data.
            r_state <= ACK;
            mem_req <= 1'b0;
            mem_we  <= 1'b0;
            if (!mem_ready) begin
              err_timeout <= 1'b1;
            end else begin
              err_timeout <= err_timeout;
            end
            if (r_state == SERVE_IF) begin
              if_ack   <= 1'b1;
              if_rdata <= mem_ready ? mem_rdata : '0;
            end else begin
              dm_ack <= 1'b1;
              if (!mem_we) begin
                dm_rdata <= mem_ready ? mem_rdata : '0;
              end else begin
                dm_rdata <= dm_rdata;
              end
            end
          end else begin
            r_wait_cnt <= r_wait_cnt + WCW'(1);
          end
        end
        ACK: begin
          r_state <= IDLE;
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one unified, multi-cycle, word-addressed memory between the IF stage (instruction fetch, read-only) and the MEM stage (data load/store) of the 5-stage pipeline.
- Arbitrates requests, sequences one memory transaction at a time, and returns data with a one-cycle ack.
- Drives stall outputs that hold the pipeline registers while a requester waits.

Parameters:
AW, 32, address width (word address; PC increments by 1)
DW, 32, data width
TIMEOUT, 255, max cycles waiting for mem_ready before abort
STARVE_MAX, 4, consecutive data grants after which a pending fetch wins

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
if_req  in  1  fetch request, held until if_ack
if_addr  in  AW  fetch address
if_ack  out  1  one-cycle pulse, if_rdata valid
if_rdata  out  DW  fetched instruction
dm_req  in  1  data request, held until dm_ack
dm_we  in  1  1=store, 0=load
dm_addr  in  AW  data address
dm_wdata  in  DW  store data
dm_ack  out  1  one-cycle pulse, dm_rdata valid for loads
dm_rdata  out  DW  load data
stall_if  out  1  IF/ID hold: if_req and not if_ack
stall_dm  out  1  whole-pipe hold: dm_req and not dm_ack
mem_req  out  1  memory request, held through transaction
mem_we  out  1  memory write enable
mem_addr  out  AW  memory address
mem_wdata  out  DW  memory write data
mem_rdata  in  DW  memory read data, valid with mem_ready
mem_ready  in  1  memory completion, single cycle
err_timeout  out  1  sticky; set on timeout, cleared only by reset

Behaviour:
- Reset (async, rst_n=0): state=IDLE. All outputs 0: mem_req, mem_we, mem_addr, mem_wdata, if_ack, dm_ack, if_rdata, dm_rdata, err_timeout. starve_cnt=0, wait_cnt=0.
- FSM states: IDLE, SERVE_IF, SERVE_DM, ACK.
- IDLE arbitration on registered inputs:
  - dm_req only -> SERVE_DM.
  - if_req only -> SERVE_IF.
  - Both -> SERVE_DM, unless starve_cnt==STARVE_MAX, then SERVE_IF.
- Entering SERVE_x: latch addr/we/wdata into the mem_* registers and assert mem_req the next cycle. mem_we=0 for IF.
- SERVE_x: hold mem_* stable. On mem_ready=1:
  - Capture mem_rdata into the x_rdata register.
  - Deassert mem_req.
  - Pulse x_ack for exactly one cycle (the cycle after mem_ready).
  - Go to ACK.
- ACK: one turnaround cycle, then IDLE. The requester drops or changes its req in ACK. Minimum transaction = 4 cycles, req to next grant.
- Latency: req seen at edge N -> mem_req high at N+1 -> ack at (cycle mem_ready seen)+1.
- starve_cnt:
  - Increments on each DM grant while if_req=1.
  - Reset to 0 on any IF grant, or on a DM grant with if_req=0.
  - Saturates at STARVE_MAX.
- Stores: dm_ack pulses and dm_rdata is unchanged.
- Timeout:
  - wait_cnt counts SERVE cycles without mem_ready.
  - At wait_cnt==TIMEOUT: set err_timeout, drop mem_req, pulse the served ack with rdata=0, go to ACK.
  - wait_cnt clears on entry to SERVE.
- mem_ready in IDLE/ACK is ignored.
- Requester dropping req mid-SERVE: the transaction still completes; the ack is still pulsed.
- Reset asserted mid-transaction aborts immediately; mem_req falls asynchronously.
- stall_if and stall_dm are combinational from req and ack only.

Test Plan:
- Lone fetch: if_req=1, if_addr=0x10, memory returns 0x8C220004 after 2 cycles -> mem_req high 1 cycle after req, mem_we=0, if_ack one pulse, if_rdata=0x8C220004, stall_if high until ack.
- Store: dm_req=1, dm_we=1, dm_addr=0x40, dm_wdata=0xDEADBEEF -> mem_we=1, mem_addr=0x40, mem_wdata=0xDEADBEEF, dm_ack pulse, dm_rdata unchanged.
- Simultaneous requests, both held, STARVE_MAX=4 -> grant order DM,DM,DM,DM,IF, then starve_cnt=0.
- Timeout: TIMEOUT=8, mem_ready never asserted -> after 8 SERVE cycles err_timeout=1, ack pulse with rdata=0, FSM back to IDLE; next request served normally, err_timeout stays 1.
- Reset mid-transaction: rst_n low during SERVE_DM -> mem_req=0 and all acks 0 immediately; after release, IDLE, err_timeout=0.
- Stray mem_ready in IDLE -> no ack, no state change.
